// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle RV32I control unit: FSM state type,
//   opcode/funct3 constants, datapath select encodings and the DECODE-state
//   next-state helper.
//   No ports (package). Optional feature macro used by the top: MEM_READY_EN.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALR_PC  = 4'd12,
      S_LUI      = 4'd13,
      S_ILLEGAL  = 4'd14
   } state_t;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // funct3 values of the supported instructions
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_JALR = 3'b000;

   // Immediate extender formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // Result mux
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   // ALU operand muxes
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // ALU operations
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   // Successor of DECODE; every encoding outside the supported subset traps.
   function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
      state_t nxt;
      nxt = S_ILLEGAL;
      case (op)
         OP_LOAD:   if (f3 == F3_LBU)                    nxt = S_MEMADR;
         OP_STORE:  if (f3 == F3_SB)                     nxt = S_MEMADR;
         OP_RTYPE:  if (f3 == F3_ADD)                    nxt = S_EXECR;
         OP_ITYPE:  if (f3 == F3_ADD)                    nxt = S_EXECI;
         OP_BRANCH: if (f3 == F3_BNE || f3 == F3_BGEU)   nxt = S_BRANCH;
         OP_JAL:                                         nxt = S_JAL;
         OP_JALR:   if (f3 == F3_JALR)                   nxt = S_JALR;
         OP_LUI:                                         nxt = S_LUI;
         default:                                        nxt = S_ILLEGAL;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Selects the ALU operation from the current control state.
//   Ports:
//     state      in  current FSM state
//     funct7b5   in  instr[30], distinguishes sub from add in R-type
//     ALUControl out 000=add, 001=sub
// -----------------------------------------------------------------------------
module alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic        funct7b5,
   output logic [2:0]  ALUControl
);

   always_comb begin
      ALUControl = ALU_ADD;
      case (state)
         S_EXECR:  ALUControl = funct7b5 ? ALU_SUB : ALU_ADD;
         // Branch compares via subtraction; zero/ltu come from the ALU.
         S_BRANCH: ALUControl = ALU_SUB;
         default:  ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Moore control FSM for a multicycle RV32I subset (add/sub, addi, lbu, sb,
//   bne, bgeu, lui, jal, jalr). Sequences the shared ALU, memory port,
//   register file and immediate extender, and counts retired instructions.
//   Optional feature macro: MEM_READY_EN (adds mem_ready handshake on FETCH,
//   MEMREAD and MEMWRITE).
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     op, funct3, funct7b5  instruction fields from the IR
//     zero, ltu             ALU flags (used in BRANCH)
//     mem_ready             memory done (only with MEM_READY_EN)
//     PCWrite..ImmSrc       datapath enables and selects
//     illegal               sticky unsupported-instruction flag
//     instret               retired instruction count, wraps
// -----------------------------------------------------------------------------
module multicycle_control
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   input  logic             ltu,
`ifdef MEM_READY_EN
   input  logic             mem_ready,
`endif
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUControl,
   output logic [2:0]       ImmSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             ready;
   logic             pc_we, ir_we, mem_we, reg_we;
   logic             retire;

`ifdef MEM_READY_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif

   // A retire is any entry into FETCH; FETCH holding on mem_ready is not one.
   assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ImmSrc    = IMM_I;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ResultSrc = RES_ALURESULT;
            ALUSrcB   = SRCB_FOUR;
            if (ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Precompute the branch/jump target OldPC+imm into ALUOut.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            if (op == OP_BRANCH)   ImmSrc = IMM_B;
            else if (op == OP_JAL) ImmSrc = IMM_J;
            state_d = decode_next(op, funct3);
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            if (op == OP_STORE) begin
               ImmSrc  = IMM_S;
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_we    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_we = 1'b1;
            if (ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            pc_we   = ((funct3 == F3_BNE) && !zero) || ((funct3 == F3_BGEU) && !ltu);
            state_d = S_FETCH;
         end
         S_JAL: begin
            // Target leaves via ALUOut while the ALU forms the link OldPC+4.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            pc_we   = 1'b1;
            state_d = S_ALUWB;
         end
         S_JALR: begin
            // rs1+imm is captured here, before rd is written, so rd==rs1 is safe.
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            state_d = S_JALR_PC;
         end
         S_JALR_PC: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            pc_we   = 1'b1;
            state_d = S_ALUWB;
         end
         S_LUI: begin
            ImmSrc    = IMM_U;
            ResultSrc = RES_IMMEXT;
            reg_we    = 1'b1;
            state_d   = S_FETCH;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = S_ILLEGAL;
         end
      endcase
   end

   // Reset overrides whatever state is still registered this cycle.
   assign PCWrite  = pc_we  & ~rst;
   assign IRWrite  = ir_we  & ~rst;
   assign MemWrite = mem_we & ~rst;
   assign RegWrite = reg_we & ~rst;
   assign instret  = instret_q;

   alu_decoder u_alu_decoder (
      .state      (state_q),
      .funct7b5   (funct7b5),
      .ALUControl (ALUControl)
   );

endmodule
